// File: rtl/poly_tone_pkg.sv
// Shared types and default sizing for the polyphonic tone sequencer.
// Channel count, field widths and the per-channel state encoding live here.
package poly_tone_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int HP_W_DEF   = 16;
    localparam int DUR_W_DEF  = 12;
    localparam int TPM_W_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } ch_state_e;

    typedef struct packed {
        logic [HP_W_DEF-1:0]  half_period;
        logic [DUR_W_DEF-1:0] duration_ms;
    } note_t;

    // A single channel still needs a one-bit select so the port never collapses to zero width.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: active note, one-deep pending slot, ms duration countdown.
// state | meaning
// IDLE  | no note loaded, tone held low, waiting for a write
// PLAY  | note or rest sounding; dur_cnt counts remaining ms ticks
module tone_channel
    import poly_tone_pkg::*;
#(
    parameter int HP_W  = HP_W_DEF,
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ms_tick,
    input  logic             wr_en,
    input  logic [HP_W-1:0]  wr_half_period,
    input  logic [DUR_W-1:0] wr_duration_ms,
    output logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic             tone
);

    ch_state_e        state;
    logic [HP_W-1:0]  hp;
    logic [HP_W-1:0]  hp_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [HP_W-1:0]  p_hp;
    logic [DUR_W-1:0] p_dur;
    logic             p_valid;
    logic             accept;
    logic             note_end;

    assign wr_ready = ~p_valid;
    assign accept   = wr_en && !p_valid && (wr_duration_ms != '0);
    assign note_end = (state == PLAY) && ms_tick && (dur_cnt == DUR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hp      <= '0;
            hp_cnt  <= '0;
            dur_cnt <= '0;
            p_hp    <= '0;
            p_dur   <= '0;
            p_valid <= 1'b0;
            tone    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= PLAY;
                        busy    <= 1'b1;
                        hp      <= wr_half_period;
                        hp_cnt  <= '0;
                        tone    <= 1'b0;
                        dur_cnt <= wr_duration_ms;
                    end
                end
                PLAY: begin
                    if (note_end) begin
                        hp_cnt <= '0;
                        tone   <= 1'b0;
                        // Handover keeps busy high so chained notes play with no gap cycle.
                        if (p_valid) begin
                            hp      <= p_hp;
                            dur_cnt <= p_dur;
                            p_valid <= 1'b0;
                        end else if (accept) begin
                            hp      <= wr_half_period;
                            dur_cnt <= wr_duration_ms;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        if (ms_tick) begin
                            dur_cnt <= dur_cnt - DUR_W'(1);
                        end
                        if (hp == '0) begin
                            tone   <= 1'b0;
                            hp_cnt <= '0;
                        end else if (hp_cnt == hp - HP_W'(1)) begin
                            tone   <= ~tone;
                            hp_cnt <= '0;
                        end else begin
                            hp_cnt <= hp_cnt + HP_W'(1);
                        end
                        if (accept) begin
                            p_hp    <= wr_half_period;
                            p_dur   <= wr_duration_ms;
                            p_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/poly_tone_sequencer.sv
// NUM_CH tone channels sharing a millisecond prescaler, with a first-order PDM
// mixer folding the active-tone count into a single speaker bit.
module poly_tone_sequencer
    import poly_tone_pkg::*;
#(
    parameter int  NUM_CH = NUM_CH_DEF,
    parameter int  HP_W   = HP_W_DEF,
    parameter int  DUR_W  = DUR_W_DEF,
    parameter int  TPM_W  = TPM_W_DEF,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TPM_W-1:0]  ticks_per_milli,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [HP_W-1:0]   wr_half_period,
    input  logic [DUR_W-1:0]  wr_duration_ms,
    output logic [NUM_CH-1:0] wr_ready,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] tone,
    output logic              mix
);

    localparam int AW = $clog2(NUM_CH) + 1;

    logic [TPM_W-1:0]  ms_cnt;
    logic              ms_tick;
    logic [NUM_CH-1:0] ch_wr;
    logic [AW-1:0]     act;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;

    // >= rather than == so lowering ticks_per_milli mid-count wraps on the next cycle.
    assign ms_tick = (ticks_per_milli <= TPM_W'(1)) ||
                     (ms_cnt >= ticks_per_milli - TPM_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else if (ms_tick) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + TPM_W'(1);
        end
    end

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr[g] = wr_en && (wr_ch == CH_W'(g));

        tone_channel #(
            .HP_W  (HP_W),
            .DUR_W (DUR_W)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .ms_tick        (ms_tick),
            .wr_en          (ch_wr[g]),
            .wr_half_period (wr_half_period),
            .wr_duration_ms (wr_duration_ms),
            .wr_ready       (wr_ready[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .tone           (tone[g])
        );
    end

    // acc stays below NUM_CH, so acc + act never exceeds 2*NUM_CH-1 and fits in AW bits.
    always_comb begin
        act = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act = act + AW'(tone[i]);
        end
        sum = acc + act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            mix <= 1'b0;
        end else if (sum >= AW'(NUM_CH)) begin
            acc <= sum - AW'(NUM_CH);
            mix <= 1'b1;
        end else begin
            acc <= sum;
            mix <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_tone_sequencer.sv
// Directed and randomized checks of poly_tone_sequencer against a note-queue
// reference model evaluated every clock.
module tb_poly_tone_sequencer;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   tpm;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [15:0]   wr_hp;
    logic [11:0]   wr_dur;
    logic [N-1:0]  wr_ready, busy, done, tone;
    logic          mix;

    poly_tone_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (tpm),
        .wr_en           (wr_en),
        .wr_ch           (wr_ch),
        .wr_half_period  (wr_hp),
        .wr_duration_ms  (wr_dur),
        .wr_ready        (wr_ready),
        .busy            (busy),
        .done            (done),
        .tone            (tone),
        .mix             (mix)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: each channel is a queue of up to two notes; the front one sounds.
    int q_hp [N][2];
    int q_dur[N][2];
    int q_n  [N];
    int q_k  [N];   // cycles since the front note was loaded
    int q_t  [N];   // ms ticks since the front note was loaded
    int pre_cnt;
    int m_acc;
    logic [N-1:0] e_busy, e_tone, e_done, e_ready;
    logic         e_mix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            q_n[c] = 0; q_k[c] = 0; q_t[c] = 0;
            q_hp[c][0] = 0; q_hp[c][1] = 0; q_dur[c][0] = 0; q_dur[c][1] = 0;
        end
        pre_cnt = 0; m_acc = 0;
        e_busy = '0; e_tone = '0; e_done = '0; e_ready = '1; e_mix = 1'b0;
    endtask

    task automatic model_edge(input logic en, input int ch, input int hp, input int dur, input int tv);
        int  act;
        bit  tick;
        bit  take;
        act = $countones(e_tone);
        if (m_acc + act >= N) begin e_mix = 1'b1; m_acc = m_acc + act - N; end
        else begin e_mix = 1'b0; m_acc = m_acc + act; end
        tick = (tv <= 1) || (pre_cnt >= tv - 1);
        pre_cnt = tick ? 0 : pre_cnt + 1;
        for (int c = 0; c < N; c++) begin
            take = en && (ch == c) && (q_n[c] < 2) && (dur != 0);
            e_done[c] = 1'b0;
            if (q_n[c] > 0) begin
                q_k[c]++;
                if (tick) q_t[c]++;
                if (q_t[c] == q_dur[c][0]) begin
                    q_hp[c][0] = q_hp[c][1]; q_dur[c][0] = q_dur[c][1];
                    q_n[c]--; q_k[c] = 0; q_t[c] = 0;
                    if (q_n[c] == 0 && !take) e_done[c] = 1'b1;
                end
            end
            if (take) begin
                q_hp[c][q_n[c]] = hp; q_dur[c][q_n[c]] = dur; q_n[c]++;
            end
            e_busy[c]  = (q_n[c] > 0);
            e_ready[c] = (q_n[c] < 2);
            e_tone[c]  = (q_n[c] > 0 && q_hp[c][0] != 0) ? 1'((q_k[c] / q_hp[c][0]) % 2) : 1'b0;
        end
    endtask

    task automatic cycle();
        logic en;
        int   ch, hp, dur, tv;
        en = wr_en; ch = wr_ch; hp = wr_hp; dur = wr_dur; tv = tpm;
        @(posedge clk);
        model_edge(en, ch, hp, dur, tv);
        #1;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("tone", 32'(tone), 32'(e_tone));
        chk("done", 32'(done), 32'(e_done));
        chk("wr_ready", 32'(wr_ready), 32'(e_ready));
        chk("mix", 32'(mix), 32'(e_mix));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input int ch, input int hp, input int dur);
        wr_en = 1'b1; wr_ch = ch[1:0]; wr_hp = hp[15:0]; wr_dur = dur[11:0];
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy != '0; i++) cycle();
        chk("wait_idle", 32'(busy), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_tone"}, 32'(tone), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_mix"}, 32'(mix), 32'h0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'hf);
    endtask

    initial begin
        int len, dones, mcount;
        rst_n = 1'b0; tpm = 16'd10; wr_en = 1'b0; wr_ch = '0; wr_hp = '0; wr_dur = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // Basic tone: 4 ms at 10 clk/ms lasts 31..40 cycles with one done pulse.
        do_write(0, 3, 4);
        len = 1; dones = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (busy[0]) len++;
            if (done[0]) dones++;
        end
        chk("basic_len_in_31_40", 32'(len >= 31 && len <= 40), 32'h1);
        chk("basic_done_count", 32'(dones), 32'h1);

        // Gapless chaining on ch1.
        do_write(1, 2, 2);
        run(3);
        do_write(1, 4, 1);
        chk("chain_not_ready", 32'(wr_ready[1]), 32'h0);
        dones = 0; len = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (done[1]) dones++;
            if (busy[1]) len++;
        end
        chk("chain_done_count", 32'(dones), 32'h1);
        chk("chain_len_min", 32'(len >= 20), 32'h1);

        // Dropped writes: full pending slot on ch2, zero duration on idle ch3.
        do_write(2, 3, 5);
        do_write(2, 6, 2);
        do_write(2, 7, 3);
        do_write(3, 5, 0);
        chk("dur0_ignored", 32'(busy[3]), 32'h0);
        wait_idle(200);

        // Rest note and fastest tone.
        do_write(3, 0, 3);
        do_write(0, 1, 2);
        run(10);
        chk("rest_silent", 32'(tone[3]), 32'h0);
        wait_idle(100);

        // Mixer: all channels hp=1, then two channels held high.
        for (int c = 0; c < N; c++) do_write(c, 1, 5);
        wait_idle(100);
        do_write(0, 200, 100);
        do_write(1, 200, 100);
        run(205);
        mcount = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (mix) mcount++;
        end
        chk("mix_half_duty", 32'(mcount >= 49 && mcount <= 51), 32'h1);
        wait_idle(1500);

        // Asynchronous reset in the middle of a note.
        do_write(0, 5, 50);
        run(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        // Randomized traffic across several prescaler settings.
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: tpm = 16'd0;
                1: tpm = 16'd1;
                2: tpm = 16'd3;
                3: tpm = 16'd10;
                default: tpm = 16'd7;
            endcase
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr_en  = 1'b1;
                    wr_ch  = 2'($urandom_range(0, 3));
                    wr_hp  = 16'($urandom_range(0, 6));
                    wr_dur = 12'($urandom_range(0, 3));
                end
                cycle();
                wr_en = 1'b0;
            end
        end
        wait_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
